muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file. It consumes the two read-port operands (rd1/rd2) plus the decoded funct3 and produces a result tagged with the destination register address, ready to drive the register file write port (ad3/wd3/we3). It is a multi-cycle radix-2 engine with a start/busy/done handshake and a flush for pipeline squash.

## Interface
- DATA_WIDTH, 32, operand/result width
- ADDRESS_WIDTH, 5, destination register tag width
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when unit is accepting (IDLE or DONE)
- flush  in  1  synchronous abort of any in-flight op
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  DATA_WIDTH  rs1 value (from rd1)
- op_b  in  DATA_WIDTH  rs2 value (from rd2)
- tag_in  in  ADDRESS_WIDTH  destination register, latched with start
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse, result valid; intended as we3
- result  out  DATA_WIDTH  registered result; holds until next accepted start
- tag_out  out  ADDRESS_WIDTH  latched tag_in; intended as ad3

## Operation
- States: IDLE, CALC, FIX, DONE. Reset -> IDLE; busy=0, done=0, result=0, tag_out=0, counter=0.
- Accept: in IDLE or DONE with start=1 and flush=0: latch funct3, tag_in, operand signs, operand magnitudes (unsigned DATA_WIDTH bits; |-2^31| = 0x8000_0000). Signed treatment: a signed for MUL/MULH/MULHSU/DIV/REM; b signed for MUL/MULH/DIV/REM; otherwise unsigned.
- Special cases on accept (skip CALC, go to FIX): divide ops with op_b=0 -> DIV/DIVU quotient all-ones, REM/REMU remainder = op_a. DIV/REM with op_a=0x8000_0000, op_b=0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
- Otherwise -> CALC, counter=0.
- CALC multiply: shift-add, 2*DATA_WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC divide: restoring, one quotient bit per cycle, MSB first, DATA_WIDTH+1-bit partial remainder.
- CALC exits to FIX when counter reaches DATA_WIDTH-1 (exactly DATA_WIDTH iteration cycles).
- FIX: apply sign. Product negated (2*W-bit two's complement) if signs differ; quotient negated if signs differ; remainder takes sign of a. Select: MUL low W bits; MULH/MULHSU/MULHU high W bits. Register result and tag_out, assert done, -> DONE.
- DONE: done=1 for this cycle only. Next: start accepted -> new op (back-to-back), else IDLE.
- start while busy: ignored, no queuing.
- flush: in any state -> IDLE next edge, done=0, result/tag_out unchanged; flush wins over simultaneous start.
- rst mid-operation: same as reset values, in-flight op discarded.

## Timing
- Accept edge N. Normal op: CALC edges N+1..N+DATA_WIDTH, FIX at edge N+DATA_WIDTH+1; done high in cycle after that edge. Latency DATA_WIDTH+2 cycles (34 at default).
- Special case: FIX at edge N+1, done high after N+1 edge (latency 2 cycles).
- busy rises the cycle after accept, falls same edge done rises.
- Back-to-back: start in DONE cycle -> next op's busy rises on following edge; no bubble.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset: rst=1 two cycles mid-CALC -> busy=0, done=0, result=0, tag_out=0; no done pulse afterwards.
- MUL 7 x -3 (0x7, 0xFFFF_FFFD), tag 5 -> done after 34 cycles, result 0xFFFF_FFEB, tag_out 5; MULH same operands -> 0xFFFF_FFFF; MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU -1 x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 0x8000_0000/3 -> 0x2AAA_AAAA; REMU -> 0x2.
- Specials, 2-cycle latency: DIV 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
- Handshake: start held high during busy -> single done; start in DONE cycle -> second op done exactly 34 cycles later, no bubble.
- Flush at CALC cycle 10 with start=1 same cycle -> IDLE, no done, result keeps prior value; next start completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// start/busy/done handshake with flush. Result and tag feed the register-file write port.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     flush,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] tag_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] tag_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [2:0]               f3_q, f3_d;
    logic [ADDRESS_WIDTH-1:0] tag_q, tag_d;
    logic                     neg_q, neg_d;
    logic                     sa_q, sa_d;
    logic                     spec_q, spec_d;
    logic [W-1:0]             spec_res_q, spec_res_d;
    logic [W-1:0]             opnd_q, opnd_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic [W-1:0]             rem_q, rem_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [W-1:0]             result_q, result_d;
    logic [ADDRESS_WIDTH-1:0] tag_out_q, tag_out_d;

    // Operand decode for the accept cycle
    logic         is_div, a_signed, b_signed, sign_a, sign_b;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf;

    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        sign_a   = a_signed & op_a[W-1];
        sign_b   = b_signed & op_b[W-1];
        mag_a    = sign_a ? ('0 - op_a) : op_a;
        mag_b    = sign_b ? ('0 - op_b) : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    end

    // One iteration step of each engine, plus the sign fix-up
    logic [W:0]     mul_sum, div_shift, div_trial;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot, remv, fix_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[W-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        prod      = neg_q ? ('0 - acc_q) : acc_q;
        quot      = neg_q ? ('0 - acc_q[W-1:0]) : acc_q[W-1:0];
        remv      = sa_q ? ('0 - rem_q) : rem_q;
        if (spec_q)
            fix_res = spec_res_q;
        else if (f3_q[2])
            fix_res = f3_q[1] ? remv : quot;
        else if (f3_q[1:0] == 2'b00)
            fix_res = prod[W-1:0];
        else
            fix_res = prod[2*W-1:W];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        tag_d      = tag_q;
        neg_d      = neg_q;
        sa_d       = sa_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        result_d   = result_q;
        tag_out_d  = tag_out_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        f3_d   = funct3;
                        tag_d  = tag_in;
                        neg_d  = sign_a ^ sign_b;
                        sa_d   = sign_a;
                        cnt_d  = '0;
                        // Multiply: multiplicand in opnd, multiplier in acc low half.
                        // Divide: divisor in opnd, dividend shifts out of acc low half.
                        opnd_d = is_div ? mag_b : mag_a;
                        acc_d  = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                        rem_d  = '0;
                        spec_d = div_zero || div_ovf;
                        if (div_zero)
                            spec_res_d = funct3[1] ? op_a : '1;
                        else
                            spec_res_d = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                        state_d = (div_zero || div_ovf) ? FIX : CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (f3_q[2]) begin
                        rem_d = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_trial[W]};
                    end else begin
                        acc_d = {mul_sum, acc_q[W-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1))
                        state_d = FIX;
                end
                FIX: begin
                    result_d  = fix_res;
                    tag_out_d = tag_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            sa_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            tag_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            tag_q      <= tag_d;
            neg_q      <= neg_d;
            sa_q       <= sa_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            tag_out_q  <= tag_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule
